eth_tx_arb: RTL and testbench

Runtime arbiter and sequencer for the single eth_tx payload port, replacing the static TX-test/loopback generic mux. Two requesters share the port: 0 = test pattern generator, 1 = loopback. The block grants one requester and streams its payload bytes. It pads the payload to the minimum length, truncates at the maximum, and pulses Eth_Pkt_Rdy. It then tracks Tx_En to enforce one frame at a time plus an inter-frame gap.

---
 rtl/eth_tx_arb_if.sv | 25 ++
 rtl/eth_tx_arb.sv | 145 ++++++++++++++
 tb/tb_eth_tx_arb.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arb_if.sv
// Payload bus shared by the two requesters, the TX arbiter and eth_tx.
interface eth_tx_arb_if;
  logic [1:0] Req;
  logic [1:0] Gnt;
  logic [7:0] Byte0;
  logic       Byte_Valid0;
  logic       Pkt_Done0;
  logic [7:0] Byte1;
  logic       Byte_Valid1;
  logic       Pkt_Done1;
  logic       Tx_En;
  logic [7:0] Eth_Byte;
  logic       Eth_Byte_Valid;
  logic       Eth_Pkt_Rdy;

  modport slave (
    input  Req, Byte0, Byte_Valid0, Pkt_Done0, Byte1, Byte_Valid1, Pkt_Done1, Tx_En,
    output Gnt, Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy
  );

  modport master (
    output Req, Byte0, Byte_Valid0, Pkt_Done0, Byte1, Byte_Valid1, Pkt_Done1, Tx_En,
    input  Gnt, Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy
  );
endinterface

// File: rtl/eth_tx_arb.sv
// Runtime arbiter for the eth_tx payload port: grants one of two requesters,
// streams its payload with min-length padding / max-length truncation, then paces frames.
module eth_tx_arb #(
  parameter int gMin_Bytes  = 46,
  parameter int gMax_Bytes  = 1500,
  parameter int gIfg_Cycles = 48,
  parameter int gTx_Timeout = 1023
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  Mode,
  eth_tx_arb_if.slave bus,
  output logic        Busy,
  output logic        Ovf_Err,
  output logic        Tmo_Err,
  output logic [15:0] Pkt_Cnt
);

  localparam logic [10:0] MIN    = 11'(gMin_Bytes);
  localparam logic [10:0] MIN_M1 = 11'(gMin_Bytes - 1);
  localparam logic [10:0] MAX    = 11'(gMax_Bytes);
  localparam logic [15:0] TMO_M1 = 16'(gTx_Timeout - 1);
  localparam logic [15:0] IFG_M1 = 16'(gIfg_Cycles - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_PAD, S_LAUNCH, S_WAIT_TX, S_IFG
  } state_t;

  state_t      st;
  logic        last;
  logic        sel;
  logic        tx_seen;
  logic [10:0] cnt;
  logic [15:0] tmr;
  logic [1:0]  gnt;
  logic [7:0]  eth_byte;
  logic        eth_valid;
  logic        pkt_rdy;

  logic        elig0, elig1, pick;
  logic [7:0]  s_byte;
  logic        s_valid, s_done;
  logic [10:0] cnt_inc;

  always_comb begin
    elig0   = bus.Req[0] && (Mode != 2'd1);
    elig1   = bus.Req[1] && (Mode != 2'd0);
    pick    = (elig0 && elig1) ? ~last : elig1;
    s_byte  = sel ? bus.Byte1       : bus.Byte0;
    s_valid = sel ? bus.Byte_Valid1 : bus.Byte_Valid0;
    // a dropped Req ends the payload exactly like Pkt_Done
    s_done  = sel ? (bus.Pkt_Done1 || !bus.Req[1]) : (bus.Pkt_Done0 || !bus.Req[0]);
    cnt_inc = cnt + {10'd0, s_valid};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      st        <= S_IDLE;
      last      <= 1'b1;
      sel       <= 1'b0;
      tx_seen   <= 1'b0;
      cnt       <= '0;
      tmr       <= '0;
      gnt       <= '0;
      eth_byte  <= '0;
      eth_valid <= 1'b0;
      pkt_rdy   <= 1'b0;
      Ovf_Err   <= 1'b0;
      Tmo_Err   <= 1'b0;
      Pkt_Cnt   <= '0;
    end else begin
      eth_valid <= 1'b0;
      pkt_rdy   <= 1'b0;
      Ovf_Err   <= 1'b0;
      Tmo_Err   <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (!bus.Tx_En && (elig0 || elig1)) begin
            sel  <= pick;
            last <= pick;
            gnt  <= pick ? 2'b10 : 2'b01;
            cnt  <= '0;
            st   <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (s_valid) begin
            eth_byte  <= s_byte;
            eth_valid <= 1'b1;
          end
          cnt <= cnt_inc;
          // a byte arriving with Pkt_Done is counted before the length decision
          if (s_done) begin
            gnt <= '0;
            st  <= (cnt_inc < MIN) ? S_PAD : S_LAUNCH;
          end else if (cnt_inc == MAX) begin
            Ovf_Err <= 1'b1;
            gnt     <= '0;
            st      <= S_LAUNCH;
          end
        end
        S_PAD: begin
          eth_byte  <= '0;
          eth_valid <= 1'b1;
          cnt       <= cnt + 11'd1;
          if (cnt == MIN_M1) st <= S_LAUNCH;
        end
        S_LAUNCH: begin
          pkt_rdy <= 1'b1;
          Pkt_Cnt <= Pkt_Cnt + 16'd1;
          tmr     <= '0;
          tx_seen <= 1'b0;
          st      <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (!tx_seen) begin
            if (bus.Tx_En) begin
              tx_seen <= 1'b1;
            end else if (tmr == TMO_M1) begin
              Tmo_Err <= 1'b1;
              st      <= S_IDLE;
            end else begin
              tmr <= tmr + 16'd1;
            end
          end else if (!bus.Tx_En) begin
            tmr <= '0;
            st  <= S_IFG;
          end
        end
        S_IFG: begin
          if (tmr == IFG_M1) st <= S_IDLE;
          else               tmr <= tmr + 16'd1;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign bus.Gnt            = gnt;
  assign bus.Eth_Byte       = eth_byte;
  assign bus.Eth_Byte_Valid = eth_valid;
  assign bus.Eth_Pkt_Rdy    = pkt_rdy;
  assign Busy               = (st != S_IDLE);

endmodule

// File: tb/tb_eth_tx_arb.sv
// Self-checking bench for eth_tx_arb: frame-level reference model of padding,
// truncation, arbitration and pacing, with randomized payloads and gaps.
module tb_eth_tx_arb;
  localparam int MIN = 46;
  localparam int MAX = 1500;
  localparam int IFG = 48;
  localparam int TMO = 1023;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [1:0]  Mode;
  logic        Busy, Ovf_Err, Tmo_Err;
  logic [15:0] Pkt_Cnt;

  eth_tx_arb_if bus();

  eth_tx_arb #(
    .gMin_Bytes(MIN), .gMax_Bytes(MAX), .gIfg_Cycles(IFG), .gTx_Timeout(TMO)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Mode(Mode), .bus(bus),
    .Busy(Busy), .Ovf_Err(Ovf_Err), .Tmo_Err(Tmo_Err), .Pkt_Cnt(Pkt_Cnt)
  );

  initial forever #10 Clk = ~Clk;

  int         n_checks, n_fail;
  int         cyc_n, n_rdy, n_ovf, n_tmo, n_stray;
  int         rdy_cyc, tmo_cyc, ovf_at, t_fall, m_pkt;
  bit         m_last, collecting;
  logic [7:0] m_hold;
  logic [7:0] q_out[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk); #1;
    cyc_n++;
    if (bus.Eth_Byte_Valid) begin
      if (collecting) q_out.push_back(bus.Eth_Byte);
      else n_stray++;
    end
    if (bus.Eth_Pkt_Rdy) begin n_rdy++; rdy_cyc = cyc_n; end
    if (Ovf_Err) begin n_ovf++; ovf_at = q_out.size(); end
    if (Tmo_Err) begin n_tmo++; tmo_cyc = cyc_n; end
  endtask

  task automatic idle_src();
    bus.Byte0 = 8'h00; bus.Byte_Valid0 = 1'b0; bus.Pkt_Done0 = 1'b0;
    bus.Byte1 = 8'h00; bus.Byte_Valid1 = 1'b0; bus.Pkt_Done1 = 1'b0;
  endtask

  // granted source gets the real stimulus, the other one gets noise
  task automatic drive(input int src, input logic [7:0] b, input logic v, input logic d);
    logic [7:0] jb;
    logic jv, jd;
    jb = 8'($urandom);
    jv = 1'($urandom);
    jd = ($urandom_range(0, 7) == 0);
    if (src == 0) begin
      bus.Byte0 = b;  bus.Byte_Valid0 = v;  bus.Pkt_Done0 = d;
      bus.Byte1 = jb; bus.Byte_Valid1 = jv; bus.Pkt_Done1 = jd;
    end else begin
      bus.Byte1 = b;  bus.Byte_Valid1 = v;  bus.Pkt_Done1 = d;
      bus.Byte0 = jb; bus.Byte_Valid0 = jv; bus.Pkt_Done0 = jd;
    end
  endtask

  function automatic int pick_ref(input logic [1:0] md, input logic [1:0] rq, input bit lst);
    bit e0, e1;
    e0 = rq[0] && (md != 2'd1);
    e1 = rq[1] && (md != 2'd0);
    if (e0 && e1) return lst ? 0 : 1;
    return e1 ? 1 : 0;
  endfunction

  task automatic lat_check(input logic v, input logic [7:0] b);
    check("lat_valid", int'(bus.Eth_Byte_Valid), int'(v));
    check("lat_byte", int'(bus.Eth_Byte), int'(b));
  endtask

  // end_kind: 0 done with last byte, 1 done one cycle later, 2 Req drop, 3 no end
  task automatic do_frame(input int len, input int end_kind, input bit gaps, input int dmode,
                          input logic [7:0] fill, input bit keep_req, input int gwait,
                          input bit chk_gap, input int flip_at, input logic [1:0] flip_mode);
    logic [7:0] pl[$];
    logic [7:0] exp_q[$];
    int src, g_cyc, acc, nbad, w, ng;
    bit exp_ovf, got;
    src = pick_ref(Mode, bus.Req, m_last);
    for (int i = 0; i < len; i++) begin
      case (dmode)
        0:       pl.push_back(8'(i));
        1:       pl.push_back(fill);
        default: pl.push_back(8'($urandom));
      endcase
    end
    for (int i = 0; i < len && i < MAX; i++) exp_q.push_back(pl[i]);
    while (exp_q.size() < MIN) exp_q.push_back(8'h00);
    exp_ovf = (len > MAX) || (len == MAX && end_kind != 0);

    q_out.delete(); n_rdy = 0; n_ovf = 0; n_tmo = 0; ovf_at = -1; collecting = 1;
    got = 0;
    for (w = 0; w < gwait && !got; w++) begin
      cyc();
      got = (bus.Gnt != 2'b00);
    end
    check("gnt_wait", int'(got), 1);
    if (!got) begin collecting = 0; return; end
    g_cyc = cyc_n;
    check("gnt_onehot", int'(bus.Gnt), (src != 0) ? 2 : 1);
    if (chk_gap) begin
      check("ifg_gap_min", int'(g_cyc - t_fall >= IFG + 1), 1);
      check("ifg_gap_max", int'(g_cyc - t_fall <= IFG + 3), 1);
    end
    m_last = (src == 1);

    acc = 0;
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        ng = $urandom_range(0, 2);
        for (int k = 0; k < ng; k++) begin
          drive(src, 8'($urandom), 1'b0, 1'b0);
          cyc();
          if (acc < MAX) lat_check(1'b0, m_hold);
        end
      end
      if (i == flip_at) Mode = flip_mode;
      drive(src, pl[i], 1'b1, (end_kind == 0 && i == len - 1));
      cyc();
      if (acc < MAX) begin
        m_hold = pl[i];
        lat_check(1'b1, pl[i]);
      end
      acc++;
    end
    case (end_kind)
      0: if (len == 0) begin drive(src, 8'h00, 1'b0, 1'b1); cyc(); lat_check(1'b0, m_hold); end
      1: begin drive(src, 8'h00, 1'b0, 1'b1); cyc(); lat_check(1'b0, m_hold); end
      2: begin drive(src, 8'h00, 1'b0, 1'b0); bus.Req[src] = 1'b0; cyc(); lat_check(1'b0, m_hold); end
      default: ;
    endcase
    idle_src();
    if (!keep_req) bus.Req = 2'b00;
    for (w = 0; w < MIN + MAX && n_rdy == 0; w++) cyc();
    check("rdy_seen", int'(n_rdy != 0), 1);
    cyc();
    cyc();
    collecting = 0;

    m_pkt++;
    check("len", q_out.size(), exp_q.size());
    nbad = 0;
    for (int i = 0; i < q_out.size() && i < exp_q.size(); i++)
      if (q_out[i] !== exp_q[i]) nbad++;
    check("payload_bad_bytes", nbad, 0);
    check("ovf_pulses", n_ovf, int'(exp_ovf));
    if (exp_ovf) check("ovf_at_byte", ovf_at, MAX);
    check("rdy_pulses", n_rdy, 1);
    check("pkt_cnt", int'(Pkt_Cnt), m_pkt & 16'hFFFF);
    check("gnt_clear", int'(bus.Gnt), 0);
    check("busy_after_launch", int'(Busy), 1);
    check("no_tmo", n_tmo, 0);
    if (exp_q.size() > len) m_hold = 8'h00;
  endtask

  task automatic tx_sim(input int dur);
    repeat ($urandom_range(1, 4)) cyc();
    bus.Tx_En = 1'b1;
    repeat (dur) cyc();
    bus.Tx_En = 1'b0;
    t_fall = cyc_n;
  endtask

  int         w;
  logic [1:0] md, rq;

  initial begin
    n_checks = 0; n_fail = 0; cyc_n = 0; n_rdy = 0; n_ovf = 0; n_tmo = 0; n_stray = 0;
    rdy_cyc = 0; tmo_cyc = 0; ovf_at = -1; t_fall = 0; m_pkt = 0;
    m_last = 1'b1; m_hold = 8'h00; collecting = 0;
    Rst = 1'b1; Mode = 2'd0; bus.Req = 2'b00; bus.Tx_En = 1'b0; idle_src();
    repeat (3) cyc();
    check("rst_gnt", int'(bus.Gnt), 0);
    check("rst_byte", int'(bus.Eth_Byte), 0);
    check("rst_valid", int'(bus.Eth_Byte_Valid), 0);
    check("rst_rdy", int'(bus.Eth_Pkt_Rdy), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_ovf", int'(Ovf_Err), 0);
    check("rst_tmo", int'(Tmo_Err), 0);
    check("rst_pkt_cnt", int'(Pkt_Cnt), 0);
    Rst = 1'b0;

    bus.Req = 2'b10;
    repeat (20) cyc();
    check("inelig_gnt", int'(bus.Gnt), 0);
    check("inelig_busy", int'(Busy), 0);
    bus.Req = 2'b00;
    cyc();

    Mode = 2'd0; bus.Req = 2'b01;
    do_frame(60, 0, 1'b0, 0, 8'h00, 1'b0, 10, 1'b0, -1, 2'd0);
    tx_sim(40);

    Mode = 2'd2; bus.Req = 2'b11;
    for (int f = 0; f < 3; f++) begin
      do_frame(50, 0, 1'b1, 2, 8'h00, 1'b1, 100, 1'b1, -1, 2'd0);
      if (f == 2) bus.Req = 2'b00;
      tx_sim(30 + f * 7);
    end

    Mode = 2'd1; bus.Req = 2'b10;
    do_frame(10, 0, 1'b0, 1, 8'hAA, 1'b0, 100, 1'b1, -1, 2'd0);
    tx_sim(25);

    Mode = 2'd3; bus.Req = 2'b01;
    do_frame(0, 0, 1'b0, 2, 8'h00, 1'b0, 100, 1'b1, -1, 2'd0);
    tx_sim(20);
    bus.Req = 2'b01;
    do_frame(45, 1, 1'b1, 2, 8'h00, 1'b0, 100, 1'b1, -1, 2'd0);
    tx_sim(20);
    bus.Req = 2'b10;
    do_frame(46, 2, 1'b1, 2, 8'h00, 1'b0, 100, 1'b1, -1, 2'd0);
    tx_sim(20);

    for (int f = 0; f < 6; f++) begin
      md = 2'($urandom_range(0, 3));
      rq = 2'($urandom_range(1, 3));
      if (md == 2'd0) rq[0] = 1'b1;
      if (md == 2'd1) rq[1] = 1'b1;
      Mode = md; bus.Req = rq;
      do_frame(int'($urandom_range(0, 120)), int'($urandom_range(0, 2)), 1'($urandom), 2,
               8'h00, 1'b0, 100, 1'b1, -1, 2'd0);
      tx_sim(int'($urandom_range(10, 60)));
    end

    Mode = 2'd0; bus.Req = 2'b01;
    do_frame(30, 0, 1'b1, 2, 8'h00, 1'b0, 100, 1'b1, 10, 2'd1);
    tx_sim(20);

    Mode = 2'd0; bus.Req = 2'b01;
    do_frame(MAX, 0, 1'b0, 2, 8'h00, 1'b0, 100, 1'b1, -1, 2'd0);
    tx_sim(20);
    bus.Req = 2'b01;
    do_frame(1600, 3, 1'b0, 2, 8'h00, 1'b0, 100, 1'b1, -1, 2'd0);
    tx_sim(20);

    bus.Req = 2'b01;
    do_frame(12, 0, 1'b0, 2, 8'h00, 1'b0, 100, 1'b1, -1, 2'd0);
    for (w = 0; w < TMO + 50 && n_tmo == 0; w++) cyc();
    check("tmo_seen", n_tmo, 1);
    check("tmo_delay", tmo_cyc - rdy_cyc, TMO);
    cyc();
    check("tmo_pulse_width", n_tmo, 1);
    check("tmo_busy_next", int'(Busy), 0);
    bus.Req = 2'b01;
    do_frame(20, 0, 1'b0, 2, 8'h00, 1'b0, 3, 1'b0, -1, 2'd0);
    tx_sim(20);

    Mode = 2'd0; bus.Req = 2'b01; collecting = 1;
    for (w = 0; w < 100 && bus.Gnt == 2'b00; w++) cyc();
    check("rst_pre_gnt", int'(bus.Gnt), 1);
    for (int i = 0; i < 20; i++) begin
      drive(0, 8'(i + 1), 1'b1, 1'b0);
      cyc();
    end
    Mode = 2'd1;
    n_rdy = 0;
    Rst = 1'b1;
    drive(0, 8'hFF, 1'b1, 1'b0);
    cyc();
    Rst = 1'b0;
    check("midrst_gnt", int'(bus.Gnt), 0);
    check("midrst_valid", int'(bus.Eth_Byte_Valid), 0);
    check("midrst_byte", int'(bus.Eth_Byte), 0);
    check("midrst_rdy", int'(bus.Eth_Pkt_Rdy), 0);
    check("midrst_busy", int'(Busy), 0);
    check("midrst_pkt_cnt", int'(Pkt_Cnt), 0);
    check("midrst_ovf", int'(Ovf_Err), 0);
    check("midrst_tmo", int'(Tmo_Err), 0);
    m_pkt = 0; m_last = 1'b1; m_hold = 8'h00;
    bus.Req = 2'b00; idle_src(); collecting = 0;
    repeat (60) cyc();
    check("midrst_no_rdy", n_rdy, 0);

    Mode = 2'd2; bus.Req = 2'b11;
    do_frame(5, 0, 1'b0, 2, 8'h00, 1'b0, 5, 1'b0, -1, 2'd0);
    tx_sim(20);
    repeat (60) cyc();

    check("stray_valid", n_stray, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
